// File: rtl/draw_rect.sv
// Rectangle rasteriser: draws a w x h box at (x,y) one pixel per clock into the VGA write port.
// Optional outline-only mode is enabled by defining DRAW_RECT_OUTLINE_EN.
module draw_rect #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int MAX_W    = 64,
    parameter int MAX_H    = 64,
    localparam int WW      = $clog2(MAX_W + 1),
    localparam int HW      = $clog2(MAX_H + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [8:0]    x,
    input  logic [7:0]    y,
    input  logic [WW-1:0] w,
    input  logic [HW-1:0] h,
    input  logic [2:0]    colour,
`ifdef DRAW_RECT_OUTLINE_EN
    input  logic          outline,
`endif
    output logic [8:0]    vga_x,
    output logic [7:0]    vga_y,
    output logic [2:0]    vga_colour,
    output logic          vga_write
);

    typedef enum logic [1:0] {IDLE, DRAW, DRAIN} state_t;

    state_t        state, state_next;
    logic [8:0]    x_base;
    logic [7:0]    y_base;
    logic [WW-1:0] w_lat;
    logic [HW-1:0] h_lat;
    logic [2:0]    colour_lat;
    logic [WW-1:0] col;
    logic [HW-1:0] row;
    logic [9:0]    px;
    logic [8:0]    py;
    logic          last_col, last_row;
    logic          accept, on_mask, pix_write;

`ifdef DRAW_RECT_OUTLINE_EN
    logic outline_lat;
`endif

    assign busy     = (state != IDLE);
    assign accept   = (state == IDLE) && start;
    assign last_col = (col == w_lat - WW'(1));
    assign last_row = (row == h_lat - HW'(1));

    // One extra bit on each coordinate so a box hanging off the right/bottom edge never wraps back on screen.
    assign px = {1'b0, x_base} + 10'(col);
    assign py = {1'b0, y_base} + 9'(row);

`ifdef DRAW_RECT_OUTLINE_EN
    assign on_mask = !outline_lat || (col == '0) || last_col || (row == '0) || last_row;
`else
    assign on_mask = 1'b1;
`endif

    assign pix_write = (state == DRAW) && (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H)) && on_mask;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (w == '0 || h == '0) ? DRAIN : DRAW;
            end
            DRAW: begin
                if (last_col && last_row) state_next = DRAIN;
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_base     <= '0;
            y_base     <= '0;
            w_lat      <= '0;
            h_lat      <= '0;
            colour_lat <= '0;
            col        <= '0;
            row        <= '0;
`ifdef DRAW_RECT_OUTLINE_EN
            outline_lat <= 1'b0;
`endif
        end else if (accept) begin
            x_base     <= x;
            y_base     <= y;
            w_lat      <= (w > WW'(MAX_W)) ? WW'(MAX_W) : w;
            h_lat      <= (h > HW'(MAX_H)) ? HW'(MAX_H) : h;
            colour_lat <= colour;
            col        <= '0;
            row        <= '0;
`ifdef DRAW_RECT_OUTLINE_EN
            outline_lat <= outline;
`endif
        end else if (state == DRAW) begin
            if (last_col) begin
                col <= '0;
                row <= row + HW'(1);
            end else begin
                col <= col + WW'(1);
            end
        end
    end

    // Output stage: coordinates only move on a real write so the VGA port sees stable values otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            done       <= 1'b0;
            vga_write  <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            done      <= (state == DRAIN);
            vga_write <= pix_write;
            if (pix_write) begin
                vga_x      <= px[8:0];
                vga_y      <= py[7:0];
                vga_colour <= colour_lat;
            end
        end
    end

endmodule

// File: tb/tb_draw_rect.sv
// Self-checking bench for draw_rect: table vectors, randomized requests against a pixel-list model,
// and hand sequences for back-to-back starts and mid-draw reset.
module tb_draw_rect;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done;
    logic [8:0] x;
    logic [7:0] y;
    logic [6:0] w;
    logic [6:0] h;
    logic [2:0] colour;
    logic       outline;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_write;

    int errors = 0;
    int checks = 0;
    int last_x = 0, last_y = 0, last_c = 0;

    typedef struct {
        int x; int y; int w; int h; int colour; int outline;
        int exp_writes; int exp_done;
    } vec_t;

    vec_t vecs[$];

    draw_rect dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .x(x), .y(y), .w(w), .h(h), .colour(colour),
`ifdef DRAW_RECT_OUTLINE_EN
        .outline(outline),
`endif
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int cyc, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, required %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ax, input int ay, input int aw, input int ah,
                                 input int ac, input int ao);
        x       = 9'(ax);
        y       = 8'(ay);
        w       = 7'(aw);
        h       = 7'(ah);
        colour  = 3'(ac);
        outline = 1'(ao);
    endtask

    // Reference: pixel k of a w x h box is (x + k%w, y + k/w); visible if on screen and, in outline
    // mode, on the border.  Sizes above 64 clamp to 64.
    task automatic run_draw(input int ax, input int ay, input int aw, input int ah, input int ac,
                            input int ao, output int n_writes, output int done_cyc);
        int we, he, n, k, pcol, prow, pxm, pym;
        bit exp_wr, ol;
`ifdef DRAW_RECT_OUTLINE_EN
        ol = (ao != 0);
`else
        ol = 1'b0;
`endif
        we = (aw > 64) ? 64 : aw;
        he = (ah > 64) ? 64 : ah;
        n  = we * he;
        n_writes = 0;
        done_cyc = -1;
        @(posedge clock); #1;
        applyStimulus(ax, ay, aw, ah, ac, ao);
        start = 1'b1;
        for (int c = 1; c <= n + 2; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin
                start = 1'b0;
                applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            end
            exp_wr = 1'b0;
            pxm = 0; pym = 0;
            if (c >= 2 && c <= n + 1) begin
                k    = c - 2;
                pcol = k % we;
                prow = k / we;
                pxm  = ax + pcol;
                pym  = ay + prow;
                exp_wr = (pxm < 320) && (pym < 240) &&
                         (!ol || pcol == 0 || pcol == we - 1 || prow == 0 || prow == he - 1);
            end
            if (vga_write) n_writes++;
            if (done && done_cyc < 0) done_cyc = c;
            checkOutput("vga_write", c, int'(vga_write), int'(exp_wr));
            checkOutput("busy", c, int'(busy), int'(c <= n + 1));
            checkOutput("done", c, int'(done), int'(c == n + 2));
            if (exp_wr) begin
                last_x = pxm; last_y = pym; last_c = ac;
            end
            checkOutput("vga_x", c, int'(vga_x), last_x);
            checkOutput("vga_y", c, int'(vga_y), last_y);
            checkOutput("vga_colour", c, int'(vga_colour), last_c);
        end
    endtask

    initial begin
        int nw, dc, cnt_w, cnt_b, cnt_d;

        reset = 1'b1;
        start = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset busy", 0, int'(busy), 0);
        checkOutput("reset done", 0, int'(done), 0);
        checkOutput("reset vga_write", 0, int'(vga_write), 0);
        checkOutput("reset vga_x", 0, int'(vga_x), 0);
        checkOutput("reset vga_y", 0, int'(vga_y), 0);
        checkOutput("reset vga_colour", 0, int'(vga_colour), 0);
        reset = 1'b0;

        vecs.push_back(vec_t'{10, 20, 4, 4, 5, 0, 16, 18});
        vecs.push_back(vec_t'{50, 60, 0, 5, 2, 0, 0, 2});
        vecs.push_back(vec_t'{7, 9, 1, 1, 6, 0, 1, 3});
        vecs.push_back(vec_t'{318, 238, 4, 4, 1, 0, 4, 18});
        vecs.push_back(vec_t'{0, 0, 100, 2, 7, 0, 128, 130});
        vecs.push_back(vec_t'{0, 0, 1, 100, 3, 0, 64, 66});
        vecs.push_back(vec_t'{300, 100, 30, 1, 4, 0, 20, 32});
        vecs.push_back(vec_t'{5, 235, 2, 10, 2, 0, 10, 22});
        vecs.push_back(vec_t'{511, 255, 3, 3, 5, 0, 0, 11});
`ifdef DRAW_RECT_OUTLINE_EN
        vecs.push_back(vec_t'{0, 0, 4, 3, 6, 1, 10, 14});
`endif

        foreach (vecs[i]) begin
            run_draw(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].colour, vecs[i].outline, nw, dc);
            checkOutput($sformatf("vec%0d write count", i), dc, nw, vecs[i].exp_writes);
            checkOutput($sformatf("vec%0d done cycle", i), dc, dc, vecs[i].exp_done);
        end

        for (int r = 0; r < 16; r++) begin
            if (r % 2 == 0)
                run_draw($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 70),
                         $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 1), nw, dc);
            else
                run_draw($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 6),
                         $urandom_range(0, 70), $urandom_range(0, 7), $urandom_range(0, 1), nw, dc);
        end

        // start held high: one 2x2 draw, restart accepted in the done cycle
        @(posedge clock); #1;
        applyStimulus(0, 0, 2, 2, 3, 0);
        start = 1'b1;
        cnt_w = 0; cnt_b = 0; cnt_d = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock); #1;
            cnt_w += int'(vga_write);
            cnt_b += int'(busy);
            cnt_d += int'(done);
        end
        checkOutput("held start writes", 5, cnt_w, 4);
        checkOutput("held start busy cycles", 5, cnt_b, 5);
        checkOutput("held start early done", 5, cnt_d, 0);
        @(posedge clock); #1;
        checkOutput("held done", 6, int'(done), 1);
        checkOutput("held busy in done", 6, int'(busy), 0);
        @(posedge clock); #1;
        start = 1'b0;
        checkOutput("restart busy", 7, int'(busy), 1);
        @(posedge clock); #1;
        checkOutput("restart write", 8, int'(vga_write), 1);
        checkOutput("restart vga_x", 8, int'(vga_x), 0);
        checkOutput("restart vga_y", 8, int'(vga_y), 0);
        repeat (4) @(posedge clock);
        #1;
        checkOutput("restart done", 12, int'(done), 1);
        last_x = 1; last_y = 1; last_c = 3;

        // reset after the 5th write of a 4x4 draw
        @(posedge clock); #1;
        applyStimulus(10, 20, 4, 4, 5, 0);
        start = 1'b1;
        cnt_w = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            cnt_w += int'(vga_write);
        end
        checkOutput("pre-reset writes", 6, cnt_w, 5);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("post-reset write", 7, int'(vga_write), 0);
        checkOutput("post-reset busy", 7, int'(busy), 0);
        checkOutput("post-reset vga_x", 7, int'(vga_x), 0);
        cnt_w = 0; cnt_d = 0;
        for (int c = 8; c <= 25; c++) begin
            @(posedge clock); #1;
            cnt_w += int'(vga_write);
            cnt_d += int'(done);
        end
        checkOutput("post-reset stray writes", 25, cnt_w, 0);
        checkOutput("post-reset stray done", 25, cnt_d, 0);
        last_x = 0; last_y = 0; last_c = 0;
        run_draw(10, 20, 4, 4, 5, 0, nw, dc);
        checkOutput("after reset write count", dc, nw, 16);
        checkOutput("after reset done cycle", dc, dc, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
